// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM address/data and decode handshake bundle for the fetch stage
interface fetch_unit_if;
  logic [7:0] addr_out_FETCH;
  logic [7:0] rom_data_FETCH;
  logic [7:0] instr_FETCH;
  logic [7:0] instr_pc_FETCH;
  logic       instr_valid_FETCH;
  logic       instr_ready_FETCH;
  logic       jump_en_FETCH;
  logic [7:0] jump_addr_FETCH;
  logic       halt_FETCH;
  logic       resume_FETCH;
  logic       halted_FETCH;
  logic       addr_err_FETCH;
  modport master (
    output addr_out_FETCH, instr_FETCH, instr_pc_FETCH, instr_valid_FETCH, halted_FETCH, addr_err_FETCH,
    input  rom_data_FETCH, instr_ready_FETCH, jump_en_FETCH, jump_addr_FETCH, halt_FETCH, resume_FETCH
  );
  modport slave (
    input  addr_out_FETCH, instr_FETCH, instr_pc_FETCH, instr_valid_FETCH, halted_FETCH, addr_err_FETCH,
    output rom_data_FETCH, instr_ready_FETCH, jump_en_FETCH, jump_addr_FETCH, halt_FETCH, resume_FETCH
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and ROM fetch stage handing instructions to decode over valid/ready
module fetch_unit #(
  parameter int         ROM_DEPTH  = 16,
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic         clk_FETCH,
  input  logic         rstn_FETCH,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {REQ, CAP, HOLD, HALTED} state_t;
  localparam logic [7:0] MASK = 8'(ROM_DEPTH - 1);
  state_t     state;
  logic [7:0] pc;
  // PC is itself a register, so the ROM address is always its registered copy
  assign bus.addr_out_FETCH = pc;
  always_ff @(posedge clk_FETCH or negedge rstn_FETCH) begin
    if (!rstn_FETCH) begin
      state                 <= REQ;
      pc                    <= START_ADDR & MASK;
      bus.instr_FETCH       <= 8'h00;
      bus.instr_pc_FETCH    <= 8'h00;
      bus.instr_valid_FETCH <= 1'b0;
      bus.halted_FETCH      <= 1'b0;
      bus.addr_err_FETCH    <= 1'b0;
    end else begin
      bus.addr_err_FETCH <= 1'b0;
      case (state)
        REQ: state <= CAP;
        CAP: begin
          bus.instr_FETCH       <= bus.rom_data_FETCH;
          bus.instr_pc_FETCH    <= pc;
          bus.instr_valid_FETCH <= 1'b1;
          pc                    <= (pc + 8'd1) & MASK;
          state                 <= HOLD;
        end
        HOLD: if (bus.instr_ready_FETCH) begin
          bus.instr_valid_FETCH <= 1'b0;
          if (bus.jump_en_FETCH) begin
            pc                 <= bus.jump_addr_FETCH & MASK;
            bus.addr_err_FETCH <= {1'b0, bus.jump_addr_FETCH} >= 9'(ROM_DEPTH);
          end
          bus.halted_FETCH <= bus.halt_FETCH;
          state            <= bus.halt_FETCH ? HALTED : REQ;
        end
        HALTED: if (bus.resume_FETCH) begin
          bus.halted_FETCH <= 1'b0;
          state            <= REQ;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table plus hand sequences for back-pressure, halt/resume and async reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  fetch_unit_if bus();
  fetch_unit #(.ROM_DEPTH(16), .START_ADDR(8'h00)) dut (
    .clk_FETCH(clk),
    .rstn_FETCH(rstn),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data_FETCH <= 8'hA0 + bus.addr_out_FETCH;
  typedef struct {
    logic       jen;
    logic [7:0] ja;
    logic [7:0] epc;
    logic [7:0] einstr;
    logic [7:0] eaddr;
    logic       eerr;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.instr_valid_FETCH !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.instr_valid_FETCH !== 1'b1) chk("valid_timeout", 32'(bus.instr_valid_FETCH), 1);
  endtask
  initial begin
    int n, last, bad;
    tbl[0] = '{1'b0, 8'h00, 8'h00, 8'hA0, 8'h01, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'h01, 8'hA1, 8'h02, 1'b0};
    tbl[2] = '{1'b1, 8'h0C, 8'h02, 8'hA2, 8'h0C, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 8'h0C, 8'hAC, 8'h0D, 1'b0};
    tbl[4] = '{1'b1, 8'h02, 8'h0D, 8'hAD, 8'h02, 1'b0};
    tbl[5] = '{1'b1, 8'h13, 8'h02, 8'hA2, 8'h03, 1'b1};
    tbl[6] = '{1'b1, 8'h0E, 8'h03, 8'hA3, 8'h0E, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h0E, 8'hAE, 8'h0F, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 8'h0F, 8'hAF, 8'h00, 1'b0};
    tbl[9] = '{1'b1, 8'h03, 8'h00, 8'hA0, 8'h03, 1'b0};
    bus.instr_ready_FETCH = 1'b1;
    bus.jump_en_FETCH = 1'b0;
    bus.jump_addr_FETCH = 8'h00;
    bus.halt_FETCH = 1'b0;
    bus.resume_FETCH = 1'b0;
    #23;
    chk("rst_valid", 32'(bus.instr_valid_FETCH), 0);
    chk("rst_addr", 32'(bus.addr_out_FETCH), 0);
    chk("rst_instr", 32'(bus.instr_FETCH), 0);
    chk("rst_halted_err", {bus.halted_FETCH, bus.addr_err_FETCH}, 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_valid(n);
    chk("first_latency", n, 2);
    last = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_valid(n);
      if (i > 0) chk("period", cyc - last, 3);
      last = cyc;
      chk($sformatf("v%0d_pc", i), 32'(bus.instr_pc_FETCH), 32'(tbl[i].epc));
      chk($sformatf("v%0d_instr", i), 32'(bus.instr_FETCH), 32'(tbl[i].einstr));
      bus.jump_en_FETCH = tbl[i].jen;
      bus.jump_addr_FETCH = tbl[i].ja;
      step();
      bus.jump_en_FETCH = 1'b0;
      chk($sformatf("v%0d_addr", i), 32'(bus.addr_out_FETCH), 32'(tbl[i].eaddr));
      chk($sformatf("v%0d_err", i), 32'(bus.addr_err_FETCH), 32'(tbl[i].eerr));
      chk($sformatf("v%0d_valid_drop", i), 32'(bus.instr_valid_FETCH), 0);
      step();
      chk($sformatf("v%0d_err_clear", i), 32'(bus.addr_err_FETCH), 0);
    end
    wait_valid(n);
    bus.instr_ready_FETCH = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.instr_valid_FETCH !== 1'b1 || bus.instr_FETCH !== 8'hA3 || bus.addr_out_FETCH !== 8'h04) bad++;
    end
    chk("bp_stable", bad, 0);
    bus.instr_ready_FETCH = 1'b1;
    step();
    wait_valid(n);
    chk("bp_next_pc", 32'(bus.instr_pc_FETCH), 4);
    chk("bp_next_instr", 32'(bus.instr_FETCH), 32'hA4);
    bus.halt_FETCH = 1'b1;
    bus.jump_en_FETCH = 1'b1;
    bus.jump_addr_FETCH = 8'h05;
    step();
    bus.halt_FETCH = 1'b0;
    bus.jump_en_FETCH = 1'b0;
    chk("halt_flag", 32'(bus.halted_FETCH), 1);
    chk("halt_addr", 32'(bus.addr_out_FETCH), 5);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.instr_valid_FETCH !== 1'b0 || bus.halted_FETCH !== 1'b1 || bus.addr_out_FETCH !== 8'h05) bad++;
    end
    chk("halt_hold", bad, 0);
    bus.resume_FETCH = 1'b1;
    step();
    bus.resume_FETCH = 1'b0;
    chk("resume_flag", 32'(bus.halted_FETCH), 0);
    wait_valid(n);
    chk("resume_pc", 32'(bus.instr_pc_FETCH), 5);
    chk("resume_instr", 32'(bus.instr_FETCH), 32'hA5);
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instr_valid_FETCH), 0);
    chk("arst_addr", 32'(bus.addr_out_FETCH), 0);
    chk("arst_instr", 32'(bus.instr_FETCH), 0);
    chk("arst_pc", 32'(bus.instr_pc_FETCH), 0);
    @(negedge clk);
    rstn = 1'b1;
    wait_valid(n);
    chk("arst_latency", n, 2);
    chk("arst_restart_pc", 32'(bus.instr_pc_FETCH), 0);
    chk("arst_restart_instr", 32'(bus.instr_FETCH), 32'hA0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
